fuse_read_ctrl: RTL and testbench

Fuse read sequencer between the PKT register wrapper and the on-chip fuse (OTP) macro. It turns the wrapper's level-style request and 32-bit fuse index into a timed single-cycle read strobe on the macro. It waits the macro's fixed read latency, then captures and holds the 32-bit word that the wrapper returns on its fuse-data read path. It also range-checks the index so accesses never leave the populated fuse array, and optionally checks macro parity.

---
 rtl/fuse_read_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fuse_read_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fuse_read_ctrl.sv
// Fuse read sequencer: turns the PKT wrapper's request/index into one timed macro strobe and holds the result.
// Optional macro odd-parity checking is compiled in when FUSE_PARITY_EN is defined.
module fuse_read_ctrl #(
    parameter int FUSE_MEM_SIZE = 34,
    parameter int READ_LAT      = 2,
    parameter int ADDR_W        = $clog2(FUSE_MEM_SIZE)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              fuse_req_i,
    input  logic [31:0]       fuse_addr_i,
    output logic [31:0]       fuse_rdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              fuse_mem_en_o,
    output logic [ADDR_W-1:0] fuse_mem_addr_o,
    input  logic [32:0]       fuse_mem_rdata_i
);

    localparam int                 CNT_W    = 4;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(0);
    localparam logic [31:0]        MEM_SIZE = 32'(FUSE_MEM_SIZE);
`ifdef FUSE_PARITY_EN
    localparam logic               PARITY_EN = 1'b1;
`else
    localparam logic               PARITY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic parity_odd_ok(input logic [32:0] word);
        return ((^word) == 1'b1);
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_req;
    logic [31:0]        r_idx;
    logic [31:0]        w_idx_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]        r_rdata;
    logic [31:0]        w_rdata_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               r_en;
    logic               w_en_nxt;
    logic [ADDR_W-1:0]  r_maddr;
    logic [ADDR_W-1:0]  w_maddr_nxt;

    logic               w_trigger;
    logic               w_in_range;
    logic               w_word_ok;

    // A held request re-fires only when the index moved away from the one last served.
    assign w_trigger  = fuse_req_i & (~r_req | (fuse_addr_i != r_idx));
    assign w_in_range = (fuse_addr_i < MEM_SIZE);
    assign w_word_ok  = ~PARITY_EN | parity_odd_ok(fuse_mem_rdata_i);

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_rdata_nxt = r_rdata;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_en_nxt    = 1'b0;
        w_maddr_nxt = r_maddr;
        case (r_state)
            IDLE: begin
                w_busy_nxt = 1'b0;
                if (w_trigger) begin
                    w_idx_nxt  = fuse_addr_i;
                    w_err_nxt  = 1'b0;
                    w_busy_nxt = 1'b1;
                    if (w_in_range) begin
                        w_state_nxt = STROBE;
                        w_en_nxt    = 1'b1;
                        w_maddr_nxt = fuse_addr_i[ADDR_W-1:0];
                    end else begin
                        w_state_nxt = DONE;
                        w_rdata_nxt = 32'h0000_0000;
                        w_err_nxt   = 1'b1;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            STROBE: begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = CNT_LOAD;
            end
            WAIT: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                    w_rdata_nxt = w_word_ok ? fuse_mem_rdata_i[31:0] : 32'h0000_0000;
                    w_err_nxt   = ~w_word_ok;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latched index, request history, latency counter and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req   <= 1'b0;
            r_idx   <= 32'h0000_0000;
            r_cnt   <= CNT_ZERO;
            r_rdata <= 32'h0000_0000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_en    <= 1'b0;
            r_maddr <= {ADDR_W{1'b0}};
        end else begin
            r_req   <= fuse_req_i;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rdata <= w_rdata_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_en    <= w_en_nxt;
            r_maddr <= w_maddr_nxt;
        end
    end

    assign fuse_rdata_o    = r_rdata;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign err_o           = r_err;
    assign fuse_mem_en_o   = r_en;
    assign fuse_mem_addr_o = r_maddr;

endmodule

// File: tb/tb_fuse_read_ctrl.sv
// Self-checking bench for fuse_read_ctrl: timeline model of the read protocol plus directed literal checks.
module tb_fuse_read_ctrl;

    localparam int RL   = 2;
    localparam int SIZE = 34;
`ifdef FUSE_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam logic [32:0] GARBAGE = 33'h0_5A5A_C3C3;

    logic        clk;
    logic        rst_ni;
    logic        fuse_req;
    logic [31:0] fuse_addr;
    logic [31:0] fuse_rdata_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        fuse_mem_en_o;
    logic [5:0]  fuse_mem_addr_o;
    logic [32:0] fuse_mem_rdata;

    fuse_read_ctrl #(.FUSE_MEM_SIZE(SIZE), .READ_LAT(RL)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .fuse_req_i       (fuse_req),
        .fuse_addr_i      (fuse_addr),
        .fuse_rdata_o     (fuse_rdata_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o),
        .fuse_mem_en_o    (fuse_mem_en_o),
        .fuse_mem_addr_o  (fuse_mem_addr_o),
        .fuse_mem_rdata_i (fuse_mem_rdata)
    );

    int n_total = 0;
    int n_pass  = 0;
    int en_cnt  = 0;
    bit chk_on  = 1'b0;
    logic [32:0] fmem [0:SIZE-1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit parity_ok(input logic [32:0] w);
        return !PAR_EN || ((^w) == 1'b1);
    endfunction

    // Fuse contents: word i = A5A5_00ii with correct odd parity, except word 9 (even parity).
    initial begin
        for (int i = 0; i < SIZE; i++) begin
            logic [31:0] w;
            w = 32'hA5A5_0000 | 32'(i);
            fmem[i] = {~^w, w};
        end
        fmem[9] = 33'h1_0000_0001;
    end

    // Macro behaviour: samples the strobe at the following edge, presents data just before READ_LAT edges later.
    initial begin
        bit          seen_en;
        logic [5:0]  seen_addr;
        logic [32:0] word;
        int          pend;
        pend = 0;
        word = GARBAGE;
        fuse_mem_rdata = GARBAGE;
        forever begin
            @(negedge clk);
            seen_en   = (fuse_mem_en_o === 1'b1);
            seen_addr = fuse_mem_addr_o;
            if (seen_en) en_cnt++;
            @(posedge clk);
            #1;
            fuse_mem_rdata = GARBAGE;
            if (!rst_ni) pend = 0;
            if (seen_en && rst_ni) begin
                pend = RL;
                word = (seen_addr < 6'd34) ? fmem[seen_addr] : GARBAGE;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) fuse_mem_rdata = word;
            end
        end
    end

    // Protocol model: tracks when each read starts and what every output must show after each edge.
    int          cyc = 0;
    int          s_upd, s_idle, s_next_ok;
    logic [31:0] s_rdata;
    logic        s_err;
    logic        m_en, m_busy, m_done, m_err, m_prev_req;
    logic [31:0] m_rdata, m_last_idx;
    logic [5:0]  m_addr;

    task automatic model_clear();
        s_upd = -1; s_idle = -1; s_next_ok = 0;
        s_rdata = 32'h0; s_err = 1'b0;
        m_en = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_prev_req = 1'b0;
        m_rdata = 32'h0; m_last_idx = 32'h0; m_addr = 6'h0;
    endtask

    initial begin
        logic [32:0] word;
        model_clear();
        forever begin
            @(posedge clk or negedge rst_ni);
            if (!rst_ni) begin
                model_clear();
            end else begin
                cyc++;
                m_en   = 1'b0;
                m_done = 1'b0;
                if (cyc == s_upd) begin
                    m_rdata = s_rdata;
                    m_err   = s_err;
                    m_done  = 1'b1;
                end
                if (cyc == s_idle) m_busy = 1'b0;
                if (cyc >= s_next_ok && fuse_req && (!m_prev_req || fuse_addr != m_last_idx)) begin
                    m_last_idx = fuse_addr;
                    m_err      = 1'b0;
                    m_busy     = 1'b1;
                    if (fuse_addr < 32'd34) begin
                        word      = fmem[fuse_addr[5:0]];
                        m_en      = 1'b1;
                        m_addr    = fuse_addr[5:0];
                        s_upd     = cyc + 1 + RL;
                        s_rdata   = parity_ok(word) ? word[31:0] : 32'h0;
                        s_err     = !parity_ok(word);
                        s_idle    = cyc + 2 + RL;
                        s_next_ok = cyc + 3 + RL;
                    end else begin
                        m_rdata   = 32'h0;
                        m_err     = 1'b1;
                        m_done    = 1'b1;
                        s_idle    = cyc + 1;
                        s_next_ok = cyc + 2;
                    end
                end
                m_prev_req = fuse_req;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on && rst_ni) begin
                chk("mdl_rdata", fuse_rdata_o, m_rdata);
                chk("mdl_busy", 32'(busy_o), 32'(m_busy));
                chk("mdl_done", 32'(done_o), 32'(m_done));
                chk("mdl_err", 32'(err_o), 32'(m_err));
                chk("mdl_en", 32'(fuse_mem_en_o), 32'(m_en));
                chk("mdl_maddr", 32'(fuse_mem_addr_o), 32'(m_addr));
            end
        end
    end

    task automatic wait_done(input string name, input int max_cyc);
        int k;
        k = 0;
        while (done_o !== 1'b1 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(done_o), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, fuse_rdata_o, 32'h0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
        chk({tag, "_en"}, 32'(fuse_mem_en_o), 32'd0);
        chk({tag, "_maddr"}, 32'(fuse_mem_addr_o), 32'd0);
    endtask

    initial begin
        int en_base;
        rst_ni = 1'b0; fuse_req = 1'b0; fuse_addr = 32'h0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_ni = 1'b1; chk_on = 1'b1;
        @(negedge clk);

        // Basic read of index 5
        en_base = en_cnt;
        fuse_addr = 32'd5; fuse_req = 1'b1;
        @(negedge clk);
        chk("t1_en", 32'(fuse_mem_en_o), 32'd1);
        chk("t1_maddr", 32'(fuse_mem_addr_o), 32'd5);
        chk("t1_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        chk("t1_en_low", 32'(fuse_mem_en_o), 32'd0);
        @(negedge clk);
        chk("t1_done_early", 32'(done_o), 32'd0);
        chk("t1_busy_mid", 32'(busy_o), 32'd1);
        @(negedge clk);
        chk("t1_done", 32'(done_o), 32'd1);
        chk("t1_rdata", fuse_rdata_o, 32'hA5A5_0005);
        chk("t1_err", 32'(err_o), 32'd0);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done_o), 32'd0);
        chk("t1_rdata_hold", fuse_rdata_o, 32'hA5A5_0005);
        chk("t1_en_pulses", 32'(en_cnt - en_base), 32'd1);

        // Index changes mid-read with the request held high
        fuse_req = 1'b0;
        en_base = en_cnt;
        @(negedge clk);
        fuse_req = 1'b1; fuse_addr = 32'd5;
        @(negedge clk);
        fuse_addr = 32'd33;
        wait_done("t2_first_done", 10);
        chk("t2_first_rdata", fuse_rdata_o, 32'hA5A5_0005);
        @(negedge clk);
        wait_done("t2_second_done", 10);
        chk("t2_second_rdata", fuse_rdata_o, 32'hA5A5_0021);
        chk("t2_second_maddr", 32'(fuse_mem_addr_o), 32'd33);
        chk("t2_en_pulses", 32'(en_cnt - en_base), 32'd2);

        // Out-of-range indices, then a valid read clears the error
        @(negedge clk);
        en_base = en_cnt;
        fuse_addr = 32'd34;
        @(negedge clk);
        chk("t3_oor_done", 32'(done_o), 32'd1);
        chk("t3_oor_err", 32'(err_o), 32'd1);
        chk("t3_oor_rdata", fuse_rdata_o, 32'h0);
        fuse_addr = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("t3_oor_done_pulse", 32'(done_o), 32'd0);
        chk("t3_oor_err_hold", 32'(err_o), 32'd1);
        @(negedge clk);
        chk("t3_max_done", 32'(done_o), 32'd1);
        chk("t3_max_err", 32'(err_o), 32'd1);
        chk("t3_max_rdata", fuse_rdata_o, 32'h0);
        chk("t3_oor_no_strobe", 32'(en_cnt - en_base), 32'd0);
        fuse_addr = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("t3_err_clear", 32'(err_o), 32'd0);
        wait_done("t3_valid_done", 10);
        chk("t3_valid_rdata", fuse_rdata_o, 32'hA5A5_0000);
        chk("t3_valid_err", 32'(err_o), 32'd0);

        // Asynchronous reset during the latency wait
        @(negedge clk);
        fuse_req = 1'b0;
        @(negedge clk);
        fuse_req = 1'b1; fuse_addr = 32'd12;
        @(negedge clk);
        @(negedge clk);
        chk("t4_busy_before", 32'(busy_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1 chk_all_zero("t4_rst");
        fuse_req = 1'b0; fuse_addr = 32'd7;
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        fuse_req = 1'b1;
        wait_done("t4_read_done", 10);
        chk("t4_read_rdata", fuse_rdata_o, 32'hA5A5_0007);
        chk("t4_read_err", 32'(err_o), 32'd0);

        // Word with even parity
        @(negedge clk);
        fuse_req = 1'b0;
        @(negedge clk);
        fuse_req = 1'b1; fuse_addr = 32'd9;
        wait_done("t5_done", 10);
`ifdef FUSE_PARITY_EN
        chk("t5_par_rdata", fuse_rdata_o, 32'h0);
        chk("t5_par_err", 32'(err_o), 32'd1);
`else
        chk("t5_par_rdata", fuse_rdata_o, 32'h0000_0001);
        chk("t5_par_err", 32'(err_o), 32'd0);
`endif
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
